rect_pulse_sequencer: RTL and testbench

- Digital sequencer for the rectangular/pulse source timing model (Td, Tr, TH, Tf, TL, amplitude).
- Steps through delay, rise, high, fall and low phases with per-phase cycle counts and outputs a ramped amplitude code per clock.
- Repeats for a programmed number of periods, or indefinitely.
- Drives a DAC-style source stage and is configured by a register front end over a valid/ready handshake.

---
 rtl/rect_pulse_sequencer_pkg.sv | 49 ++++
 rtl/rect_pulse_sequencer_if.sv | 22 ++
 rtl/rect_pulse_sequencer_phase_timer.sv | 27 ++
 rtl/rect_pulse_sequencer.sv | 111 +++++++++++
 tb/tb_rect_pulse_sequencer.sv | 167 ++++++++++++++++
 5 files changed

// File: rtl/rect_pulse_sequencer_pkg.sv
// Shared types for the rectangular pulse sequencer: phase encoding, config bundle,
// and helpers that walk the phase order while skipping zero-length phases.
package rect_seq_pkg;

  localparam int CNT_W = 16;
  localparam int LVL_W = 12;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_DELAY = 3'd1,
    S_RISE  = 3'd2,
    S_HIGH  = 3'd3,
    S_FALL  = 3'd4,
    S_LOW   = 3'd5
  } state_t;

  typedef struct packed {
    logic [CNT_W-1:0] td;
    logic [CNT_W-1:0] tr;
    logic [CNT_W-1:0] th;
    logic [CNT_W-1:0] tf;
    logic [CNT_W-1:0] tl;
    logic [LVL_W-1:0] level;
    logic [LVL_W-1:0] rstep;
    logic [LVL_W-1:0] fstep;
    logic [CNT_W-1:0] periods;
  } cfg_t;

  function automatic logic [CNT_W-1:0] phase_dur(state_t s, cfg_t c);
    case (s)
      S_DELAY: return c.td;
      S_RISE:  return c.tr;
      S_HIGH:  return c.th;
      S_FALL:  return c.tf;
      S_LOW:   return c.tl;
      default: return '0;
    endcase
  endfunction

  // First non-zero phase strictly after cur; S_IDLE means the period is exhausted.
  function automatic state_t next_phase(state_t cur, cfg_t c);
    state_t nxt;
    nxt = S_IDLE;
    for (int i = 5; i >= 1; i--)
      if (i > int'(cur) && phase_dur(state_t'(i[2:0]), c) != '0) nxt = state_t'(i[2:0]);
    return nxt;
  endfunction

endpackage

// File: rtl/rect_pulse_sequencer_if.sv
// Configuration handshake bundle: register front end (master) to sequencer (slave).
interface rect_pulse_sequencer_if #(
  parameter int CNT_W = rect_seq_pkg::CNT_W,
  parameter int LVL_W = rect_seq_pkg::LVL_W
);
  logic             cfg_valid;
  logic             cfg_ready;
  logic [CNT_W-1:0] cfg_td, cfg_tr, cfg_th, cfg_tf, cfg_tl, cfg_periods;
  logic [LVL_W-1:0] cfg_level, cfg_rstep, cfg_fstep;

  modport master (
    output cfg_valid, cfg_td, cfg_tr, cfg_th, cfg_tf, cfg_tl, cfg_periods,
           cfg_level, cfg_rstep, cfg_fstep,
    input  cfg_ready
  );

  modport slave (
    input  cfg_valid, cfg_td, cfg_tr, cfg_th, cfg_tf, cfg_tl, cfg_periods,
           cfg_level, cfg_rstep, cfg_fstep,
    output cfg_ready
  );
endinterface

// File: rtl/rect_pulse_sequencer_phase_timer.sv
// Loadable down-counter timing one phase: load duration-1 on entry, expire at zero.
module phase_timer #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic [CNT_W-1:0] value,
  output logic             expire
);
  logic [CNT_W-1:0] value_q, value_d;

  always_comb begin
    value_d = value_q;
    if (load)               value_d = load_val;
    else if (value_q != '0) value_d = value_q - CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) value_q <= '0;
    else     value_q <= value_d;
  end

  assign value  = value_q;
  assign expire = (value_q == '0);
endmodule

// File: rtl/rect_pulse_sequencer.sv
// Pulse source sequencer: DELAY/RISE/HIGH/FALL/LOW phases with a saturating amplitude
// ramp, repeated for a programmed number of periods (0 = until stop).
module rect_pulse_sequencer #(
  parameter int CNT_W = rect_seq_pkg::CNT_W,
  parameter int LVL_W = rect_seq_pkg::LVL_W
) (
  input  logic                    clk,
  input  logic                    rst,
  rect_pulse_sequencer_if.slave   cfg,
  input  logic                    start,
  input  logic                    stop,
  output logic [LVL_W-1:0]        level_out,
  output logic [2:0]              phase_out,
  output logic                    busy,
  output logic                    done,
  output logic                    err
);
  import rect_seq_pkg::*;

  cfg_t             cfg_q, cfg_d, cfg_in, cfg_eff;
  state_t           state_q, state_d, nxt;
  logic [LVL_W-1:0] level_q, level_d;
  logic [CNT_W-1:0] period_q, period_d, period_inc;
  logic [CNT_W-1:0] tmr_load_val, tmr_value;
  logic [LVL_W:0]   rise_sum;
  logic             err_q, err_d, done_c, tmr_load, tmr_expire, idle;

  assign idle          = (state_q == S_IDLE);
  assign cfg.cfg_ready = idle;
  assign cfg_in = {cfg.cfg_td, cfg.cfg_tr, cfg.cfg_th, cfg.cfg_tf, cfg.cfg_tl,
                   cfg.cfg_level, cfg.cfg_rstep, cfg.cfg_fstep, cfg.cfg_periods};
  // A config accepted in the same cycle as start is the one that start uses.
  assign cfg_eff = (idle && cfg.cfg_valid) ? cfg_in : cfg_q;
  assign cfg_d   = cfg_eff;

  always_comb begin
    state_d    = state_q;
    period_d   = period_q;
    err_d      = 1'b0;
    done_c     = 1'b0;
    nxt        = next_phase(state_q, cfg_eff);
    period_inc = period_q + CNT_W'(1);
    if (idle) begin
      if (start && !stop) begin
        if (~|{cfg_eff.tr, cfg_eff.th, cfg_eff.tf, cfg_eff.tl}) err_d = 1'b1;
        else begin
          state_d  = nxt;
          period_d = '0;
        end
      end
    end else if (stop) begin
      state_d = S_IDLE;
    end else if (tmr_expire) begin
      if (nxt != S_IDLE) state_d = nxt;
      else begin
        period_d = period_inc;
        if (cfg_eff.periods != '0 && period_inc == cfg_eff.periods) begin
          done_c  = 1'b1;
          state_d = S_IDLE;
        end else begin
          state_d = next_phase(S_DELAY, cfg_eff);  // later periods skip DELAY
        end
      end
    end
    tmr_load     = (state_d != S_IDLE) && (idle || tmr_expire);
    tmr_load_val = phase_dur(state_d, cfg_eff) - CNT_W'(1);
  end

  // Level follows the phase being entered/held; HIGH and LOW force their levels.
  always_comb begin
    rise_sum = {1'b0, level_q} + {1'b0, cfg_eff.rstep};
    case (state_d)
      S_RISE:  level_d = (rise_sum > {1'b0, cfg_eff.level}) ? cfg_eff.level : rise_sum[LVL_W-1:0];
      S_HIGH:  level_d = cfg_eff.level;
      S_FALL:  level_d = (level_q > cfg_eff.fstep) ? level_q - cfg_eff.fstep : '0;
      default: level_d = '0;
    endcase
  end

  phase_timer #(.CNT_W(CNT_W)) u_tmr (
    .clk      (clk),
    .rst      (rst),
    .load     (tmr_load),
    .load_val (tmr_load_val),
    .value    (tmr_value),
    .expire   (tmr_expire)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      level_q  <= '0;
      period_q <= '0;
      err_q    <= 1'b0;
      cfg_q    <= '0;
    end else begin
      state_q  <= state_d;
      level_q  <= level_d;
      period_q <= period_d;
      err_q    <= err_d;
      cfg_q    <= cfg_d;
      assert (idle || tmr_value < phase_dur(state_q, cfg_q));
    end
  end

  assign level_out = level_q;
  assign phase_out = state_q;
  assign busy      = !idle;
  assign done      = done_c && !rst;
  assign err       = err_q;
endmodule

// File: tb/tb_rect_pulse_sequencer.sv
// Directed bench for rect_pulse_sequencer: hand-computed waveforms checked each cycle.
module tb_rect_pulse_sequencer;
  logic        clk = 1'b0;
  logic        rst, start, stop;
  logic [11:0] level_out;
  logic [2:0]  phase_out;
  logic        busy, done, err;
  int          checks = 0;
  int          errors = 0;

  int lv1[16] = '{0, 0, 30, 60, 90, 100, 100, 100, 100, 70, 40, 10, 0, 0, 0, 0};
  int ph1[16] = '{1, 1, 2, 2, 2, 2, 3, 3, 3, 4, 4, 4, 4, 5, 5, 5};

  rect_pulse_sequencer_if #(.CNT_W(16), .LVL_W(12)) cfg_if();

  rect_pulse_sequencer #(.CNT_W(16), .LVL_W(12)) dut (
    .clk       (clk),
    .rst       (rst),
    .cfg       (cfg_if),
    .start     (start),
    .stop      (stop),
    .level_out (level_out),
    .phase_out (phase_out),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic set_cfg(input int td, tr, th, tf, tl, lvl, rs, fs, per);
    cfg_if.cfg_td      = 16'(td);
    cfg_if.cfg_tr      = 16'(tr);
    cfg_if.cfg_th      = 16'(th);
    cfg_if.cfg_tf      = 16'(tf);
    cfg_if.cfg_tl      = 16'(tl);
    cfg_if.cfg_level   = 12'(lvl);
    cfg_if.cfg_rstep   = 12'(rs);
    cfg_if.cfg_fstep   = 12'(fs);
    cfg_if.cfg_periods = 16'(per);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; stop = 1'b0; cfg_if.cfg_valid = 1'b0;
    set_cfg(0, 0, 0, 0, 0, 0, 0, 0, 0);
    step(); step();
    rst = 1'b0;
    chk("rst_level", level_out, 0);
    chk("rst_phase", phase_out, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ready", cfg_if.cfg_ready, 1);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_period", dut.period_q, 0);

    // Full trapezoid, one period; ramp saturates at 100 and floors at 0.
    set_cfg(2, 4, 3, 4, 3, 100, 30, 30, 1);
    cfg_if.cfg_valid = 1'b1; step(); cfg_if.cfg_valid = 1'b0;
    start = 1'b1; step(); start = 1'b0;
    for (int i = 0; i < 16; i++) begin
      chk($sformatf("t1_level[%0d]", i), level_out, lv1[i]);
      chk($sformatf("t1_phase[%0d]", i), phase_out, ph1[i]);
      chk($sformatf("t1_done[%0d]", i), done, (i == 15));
      step();
    end
    chk("t1_busy_after", busy, 0);
    chk("t1_level_after", level_out, 0);

    // Square wave, zero-length ramps and delay, three periods.
    set_cfg(0, 0, 2, 0, 2, 50, 0, 0, 3);
    cfg_if.cfg_valid = 1'b1; step(); cfg_if.cfg_valid = 1'b0;
    start = 1'b1; step(); start = 1'b0;
    for (int i = 0; i < 12; i++) begin
      chk($sformatf("t2_level[%0d]", i), level_out, ((i % 4) < 2) ? 50 : 0);
      chk($sformatf("t2_phase[%0d]", i), phase_out, ((i % 4) < 2) ? 3 : 5);
      chk($sformatf("t2_done[%0d]", i), done, (i == 11));
      chk($sformatf("t2_busy[%0d]", i), busy, 1);
      step();
    end
    chk("t2_busy_after", busy, 0);

    // Only a delay programmed: start is rejected.
    set_cfg(5, 0, 0, 0, 0, 77, 1, 1, 1);
    cfg_if.cfg_valid = 1'b1; start = 1'b1; step();
    cfg_if.cfg_valid = 1'b0; start = 1'b0;
    chk("t3_err", err, 1);
    chk("t3_busy", busy, 0);
    chk("t3_level", level_out, 0);
    step();
    chk("t3_err_clear", err, 0);
    chk("t3_busy2", busy, 0);

    // Continuous run aborted by stop on the first HIGH cycle.
    set_cfg(2, 4, 3, 4, 3, 100, 30, 30, 0);
    cfg_if.cfg_valid = 1'b1; start = 1'b1; step();
    cfg_if.cfg_valid = 1'b0; start = 1'b0;
    repeat (6) step();
    chk("t4_phase_high", phase_out, 3);
    chk("t4_level_high", level_out, 100);
    stop = 1'b1;
    chk("t4_done_stop", done, 0);
    step(); stop = 1'b0;
    chk("t4_phase", phase_out, 0);
    chk("t4_level", level_out, 0);
    chk("t4_busy", busy, 0);
    chk("t4_ready", cfg_if.cfg_ready, 1);
    chk("t4_done", done, 0);

    // stop beats start in IDLE.
    start = 1'b1; stop = 1'b1; step(); start = 1'b0; stop = 1'b0;
    chk("t4b_busy", busy, 0);
    chk("t4b_err", err, 0);

    // Config offered with start is used; config offered while busy is ignored.
    set_cfg(0, 0, 2, 0, 2, 200, 0, 0, 2);
    cfg_if.cfg_valid = 1'b1; start = 1'b1; step(); start = 1'b0;
    cfg_if.cfg_level = 12'd99; cfg_if.cfg_th = 16'd7;
    chk("t5_phase1", phase_out, 3);
    chk("t5_level1", level_out, 200);
    chk("t5_ready_busy", cfg_if.cfg_ready, 0);
    repeat (4) step();
    chk("t5_phase5", phase_out, 3);
    chk("t5_level5", level_out, 200);
    cfg_if.cfg_valid = 1'b0;
    repeat (3) step();
    chk("t5_phase8", phase_out, 5);
    chk("t5_done8", done, 1);
    step();
    chk("t5_busy_after", busy, 0);

    // Reset in the second period's RISE at level 60.
    set_cfg(2, 4, 3, 4, 3, 100, 30, 30, 0);
    cfg_if.cfg_valid = 1'b1; start = 1'b1; step();
    cfg_if.cfg_valid = 1'b0; start = 1'b0;
    repeat (17) step();
    chk("t6_level_pre", level_out, 60);
    chk("t6_phase_pre", phase_out, 2);
    chk("t6_period_pre", dut.period_q, 1);
    rst = 1'b1; step(); rst = 1'b0;
    chk("t6_level", level_out, 0);
    chk("t6_phase", phase_out, 0);
    chk("t6_busy", busy, 0);
    chk("t6_period", dut.period_q, 0);
    chk("t6_ready", cfg_if.cfg_ready, 1);
    chk("t6_done", done, 0);
    // Config registers were cleared, so a bare start is now rejected.
    start = 1'b1; step(); start = 1'b0;
    chk("t6_err_cfg_zero", err, 1);
    chk("t6_busy_cfg_zero", busy, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
